// File: rtl/decode_pkg.sv
// Shared types for the RV32I/RV64I decode stage.
// Opcodes, instruction formats and the decoded bundle.
package decode_pkg;

  localparam logic [6:0] OP_REG    = 7'd51;
  localparam logic [6:0] OP_IMM    = 7'd19;
  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_LUI    = 7'd55;
  localparam logic [6:0] OP_AUIPC  = 7'd23;
  localparam logic [6:0] OP_JAL    = 7'd111;
  localparam logic [6:0] OP_JALR   = 7'd103;
  localparam logic [6:0] OP_SYSTEM = 7'd115;
  localparam logic [6:0] OP_FENCE  = 7'd15;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_SYS,
    FMT_NONE
  } fmt_e;

  // imm is always carried at 64 bits; the stage trims to XLEN
  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [63:0] imm;
    fmt_e        fmt;
    logic        rd_we;
    logic        use_rs1;
    logic        use_rs2;
    logic        illegal;
  } dec_t;

endpackage

// File: rtl/decode_comb.sv
// Combinational RV32I/RV64I field decoder.
// Produces a zero-filled bundle with legality and register usage.
module decode_comb
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter bit HAS_M = 1'b0
) (
  input  logic [31:0] instr,
  output dec_t        dec
);

  localparam bit RV64 = (XLEN == 64);

  logic [6:0]  op;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        s;
  logic [63:0] imm_i;
  logic [63:0] imm_s;
  logic [63:0] imm_b;
  logic [63:0] imm_u;
  logic [63:0] imm_j;
  logic [63:0] imm_z;

  assign op = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  assign s  = instr[31];

  assign imm_i = {{52{s}}, instr[31:20]};
  assign imm_s = {{52{s}}, instr[31:25], instr[11:7]};
  assign imm_b = {{51{s}}, instr[31], instr[7],
                  instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {{32{s}}, instr[31:12], 12'b0};
  assign imm_j = {{43{s}}, instr[31], instr[19:12],
                  instr[20], instr[30:21], 1'b0};
  assign imm_z = {52'b0, instr[31:20]};

  fmt_e        fmt;
  logic [63:0] imm;
  logic        we;
  logic        u1;
  logic        u2;
  logic        f7_en;
  logic        bad;
  logic        ill;

  always_comb begin
    fmt   = FMT_NONE;
    imm   = '0;
    we    = 1'b0;
    u1    = 1'b0;
    u2    = 1'b0;
    f7_en = 1'b0;
    bad   = 1'b0;
    unique case (1'b1)
      (op == OP_REG): begin
        fmt   = FMT_R;
        we    = 1'b1;
        u1    = 1'b1;
        u2    = 1'b1;
        f7_en = 1'b1;
        bad   = !(f7 == 7'h00 || f7 == 7'h20 ||
                  (HAS_M && f7 == 7'h01)) ||
                (f7 == 7'h20 && f3 != 3'd0 && f3 != 3'd5);
      end
      (op == OP_IMM): begin
        fmt   = FMT_I;
        imm   = imm_i;
        we    = 1'b1;
        u1    = 1'b1;
        f7_en = (f3 == 3'd1) || (f3 == 3'd5);
        bad   = (f3 == 3'd1 && f7 != 7'h00) ||
                (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
      end
      (op == OP_LOAD): begin
        fmt = FMT_I;
        imm = imm_i;
        we  = 1'b1;
        u1  = 1'b1;
        bad = RV64 ? (f3 == 3'd7)
                   : (f3 == 3'd3 || f3[2:1] == 2'b11);
      end
      (op == OP_JALR): begin
        fmt = FMT_I;
        imm = imm_i;
        we  = 1'b1;
        u1  = 1'b1;
        bad = (f3 != 3'd0);
      end
      (op == OP_FENCE): begin
        fmt = FMT_I;
        imm = imm_i;
      end
      (op == OP_STORE): begin
        fmt = FMT_S;
        imm = imm_s;
        u1  = 1'b1;
        u2  = 1'b1;
        bad = f3 > (RV64 ? 3'd3 : 3'd2);
      end
      (op == OP_BRANCH): begin
        fmt = FMT_B;
        imm = imm_b;
        u1  = 1'b1;
        u2  = 1'b1;
        bad = (f3[2:1] == 2'b01);
      end
      (op == OP_LUI) || (op == OP_AUIPC): begin
        fmt = FMT_U;
        imm = imm_u;
        we  = 1'b1;
      end
      (op == OP_JAL): begin
        fmt = FMT_J;
        imm = imm_j;
        we  = 1'b1;
      end
      (op == OP_SYSTEM): begin
        fmt = FMT_SYS;
        imm = imm_z;
      end
      default: bad = 1'b1;
    endcase
  end

  // raw fields survive an illegal decode; only the usage flags drop
  always_comb begin
    ill         = bad || (instr[1:0] != 2'b11);
    dec         = '0;
    dec.opcode  = op;
    dec.fmt     = fmt;
    dec.imm     = imm;
    dec.illegal = ill;
    dec.rd      = (fmt inside {FMT_R, FMT_I, FMT_U, FMT_J})
                  ? instr[11:7] : 5'd0;
    dec.rs1     = (fmt inside {FMT_R, FMT_I, FMT_S, FMT_B})
                  ? instr[19:15] : 5'd0;
    dec.rs2     = (fmt inside {FMT_R, FMT_S, FMT_B})
                  ? instr[24:20] : 5'd0;
    dec.funct3  = (fmt inside {FMT_R, FMT_I, FMT_S,
                               FMT_B, FMT_SYS})
                  ? f3 : 3'd0;
    dec.funct7  = f7_en ? f7 : 7'd0;
    dec.rd_we   = we && !ill;
    dec.use_rs1 = u1 && !ill;
    dec.use_rs2 = u2 && !ill;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with valid/ready handshake,
// flush and saturating decode/illegal statistics.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter bit HAS_M = 1'b0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       out_opcode,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [2:0]       out_funct3,
  output logic [6:0]       out_funct7,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_rd_we,
  output logic             out_use_rs1,
  output logic             out_use_rs2,
  output logic             out_illegal,
  output logic [CNT_W-1:0] cnt_decoded,
  output logic [CNT_W-1:0] cnt_illegal
);

  dec_t             d;
  dec_t             q;
  logic             vld;
  logic             rdy;
  logic             acc;
  logic [CNT_W-1:0] n_dec;
  logic [CNT_W-1:0] n_ill;

  decode_comb #(
    .XLEN  (XLEN),
    .HAS_M (HAS_M)
  ) u_comb (
    .instr (in_instr),
    .dec   (d)
  );

  // rdy keeps in_ready low through reset and the first edge after it
  assign in_ready = rdy && !flush && (!vld || out_ready);
  assign acc      = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy   <= 1'b0;
      vld   <= 1'b0;
      q     <= '0;
      n_dec <= '0;
      n_ill <= '0;
    end else begin
      rdy <= 1'b1;
      if (flush)
        vld <= 1'b0;
      else if (acc)
        vld <= 1'b1;
      else if (out_ready)
        vld <= 1'b0;
      if (acc) begin
        q <= d;
        if (!(&n_dec))
          n_dec <= n_dec + CNT_W'(1);
        if (d.illegal && !(&n_ill))
          n_ill <= n_ill + CNT_W'(1);
      end
    end
  end

  if (XLEN < 64) begin : g_trim
    logic unused_imm;
    assign unused_imm = ^q.imm[63:XLEN];
  end

  assign out_valid   = vld;
  assign out_opcode  = q.opcode;
  assign out_rd      = q.rd;
  assign out_rs1     = q.rs1;
  assign out_rs2     = q.rs2;
  assign out_funct3  = q.funct3;
  assign out_funct7  = q.funct7;
  assign out_imm     = q.imm[XLEN-1:0];
  assign out_fmt     = q.fmt;
  assign out_rd_we   = q.rd_we;
  assign out_use_rs1 = q.use_rs1;
  assign out_use_rs2 = q.use_rs2;
  assign out_illegal = q.illegal;
  assign cnt_decoded = n_dec;
  assign cnt_illegal = n_ill;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench: RV32 without M and RV64 with M,
// driven in lockstep from one directed vector table.
module tb_decode_stage;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic        out_ready = 1'b1;

  logic        in_ready_a, out_valid_a;
  logic [6:0]  op_a, f7_a;
  logic [4:0]  rd_a, rs1_a, rs2_a;
  logic [2:0]  f3_a, fmt_a;
  logic [31:0] imm_a;
  logic        we_a, u1_a, u2_a, ill_a;
  logic [3:0]  cd_a, ci_a;

  logic        in_ready_b, out_valid_b;
  logic [6:0]  op_b, f7_b;
  logic [4:0]  rd_b, rs1_b, rs2_b;
  logic [2:0]  f3_b, fmt_b;
  logic [63:0] imm_b;
  logic        we_b, u1_b, u2_b, ill_b;
  logic [3:0]  cd_b, ci_b;

  decode_stage #(.XLEN(32), .HAS_M(1'b0), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_a),
    .in_instr(in_instr), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_opcode(op_a),
    .out_rd(rd_a), .out_rs1(rs1_a), .out_rs2(rs2_a),
    .out_funct3(f3_a), .out_funct7(f7_a),
    .out_imm(imm_a), .out_fmt(fmt_a),
    .out_rd_we(we_a), .out_use_rs1(u1_a),
    .out_use_rs2(u2_a), .out_illegal(ill_a),
    .cnt_decoded(cd_a), .cnt_illegal(ci_a)
  );

  decode_stage #(.XLEN(64), .HAS_M(1'b1), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_b),
    .in_instr(in_instr), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_opcode(op_b),
    .out_rd(rd_b), .out_rs1(rs1_b), .out_rs2(rs2_b),
    .out_funct3(f3_b), .out_funct7(f7_b),
    .out_imm(imm_b), .out_fmt(fmt_b),
    .out_rd_we(we_b), .out_use_rs1(u1_b),
    .out_use_rs2(u2_b), .out_illegal(ill_b),
    .cnt_decoded(cd_b), .cnt_illegal(ci_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    fmt_e        fmt;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] imm;
    logic        we, u1, u2, ia, ib;
  } vec_t;

  vec_t vt[$];
  vec_t qa[$];
  vec_t qb[$];
  int   total = 0;
  int   bad = 0;
  int   last_wait = 0;

  logic [127:0] act_a, act_b;
  assign act_a = 128'({op_a, rd_a, rs1_a, rs2_a, f3_a, f7_a,
                       imm_a, fmt_a, we_a, u1_a, u2_a, ill_a});
  assign act_b = 128'({op_b, rd_b, rs1_b, rs2_b, f3_b, f7_b,
                       imm_b, fmt_b, we_b, u1_b, u2_b, ill_b});

  function automatic void chk(string nm, logic [127:0] act,
                              logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  function automatic vec_t mk(logic [31:0] ins, fmt_e f,
      int rd, int rs1, int rs2, int f3, int f7,
      logic [63:0] imm, int we, int u1, int u2, int ia, int ib);
    vec_t v;
    v.instr = ins;  v.fmt = f;
    v.rd = 5'(rd);  v.rs1 = 5'(rs1);  v.rs2 = 5'(rs2);
    v.f3 = 3'(f3);  v.f7 = 7'(f7);    v.imm = imm;
    v.we = 1'(we);  v.u1 = 1'(u1);    v.u2 = 1'(u2);
    v.ia = 1'(ia);  v.ib = 1'(ib);
    return v;
  endfunction

  // usage flags are expected low whenever that variant sees illegal
  function automatic logic [127:0] exp_a(vec_t v);
    return 128'({v.instr[6:0], v.rd, v.rs1, v.rs2, v.f3, v.f7,
                 v.imm[31:0], v.fmt, v.we & ~v.ia,
                 v.u1 & ~v.ia, v.u2 & ~v.ia, v.ia});
  endfunction

  function automatic logic [127:0] exp_b(vec_t v);
    return 128'({v.instr[6:0], v.rd, v.rs1, v.rs2, v.f3, v.f7,
                 v.imm, v.fmt, v.we & ~v.ib,
                 v.u1 & ~v.ib, v.u2 & ~v.ib, v.ib});
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (flush) begin
        if (out_valid_a && qa.size() > 0) void'(qa.pop_front());
      end else if (out_valid_a) begin
        if (qa.size() == 0) begin
          total++; bad++;
          $display("FAIL a_spurious: got valid want idle");
        end else begin
          chk("a_bundle", act_a, exp_a(qa[0]));
          if (out_ready) void'(qa.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (flush) begin
        if (out_valid_b && qb.size() > 0) void'(qb.pop_front());
      end else if (out_valid_b) begin
        if (qb.size() == 0) begin
          total++; bad++;
          $display("FAIL b_spurious: got valid want idle");
        end else begin
          chk("b_bundle", act_b, exp_b(qb[0]));
          if (out_ready) void'(qb.pop_front());
        end
      end
    end
  end

  task automatic send(input int i);
    int n = 0;
    in_valid = 1'b1;
    in_instr = vt[i].instr;
    @(negedge clk);
    while (!in_ready_a && n < 20) begin
      @(negedge clk);
      n++;
    end
    last_wait = n;
    chk("send_ready", in_ready_a, 1);
    if (in_ready_a) begin
      qa.push_back(vt[i]);
      qb.push_back(vt[i]);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("drain_q", {qa.size(), qb.size()}, 0);
    chk("drain_valid", {out_valid_a, out_valid_b}, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    #1;
    chk("rst_a_bundle", act_a, 0);
    chk("rst_b_bundle", act_b, 0);
    chk("rst_a_ctl", {out_valid_a, in_ready_a, cd_a, ci_a}, 0);
    chk("rst_b_ctl", {out_valid_b, in_ready_b, cd_b, ci_b}, 0);
    qa.delete();
    qb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_rdy0", {in_ready_a, in_ready_b}, 0);
    @(posedge clk); #1;
    chk("rst_rdy1", {in_ready_a, in_ready_b}, 2'b11);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vt.push_back(mk(32'h00500093, FMT_I, 1, 0, 0, 0, 0,
                    64'd5, 1, 1, 0, 0, 0));
    vt.push_back(mk(32'hFE000EE3, FMT_B, 0, 0, 0, 0, 0,
                    64'hFFFF_FFFF_FFFF_FFFC, 0, 1, 1, 0, 0));
    vt.push_back(mk(32'h02208033, FMT_R, 0, 1, 2, 0, 1,
                    64'd0, 1, 1, 1, 1, 0));
    vt.push_back(mk(32'h00000000, FMT_NONE, 0, 0, 0, 0, 0,
                    64'd0, 0, 0, 0, 1, 1));
    vt.push_back(mk(32'h0020A423, FMT_S, 0, 1, 2, 2, 0,
                    64'd8, 0, 1, 1, 0, 0));
    vt.push_back(mk(32'h800002B7, FMT_U, 5, 0, 0, 0, 0,
                    64'hFFFF_FFFF_8000_0000, 1, 0, 0, 0, 0));
    vt.push_back(mk(32'h001000EF, FMT_J, 1, 0, 0, 0, 0,
                    64'h800, 1, 0, 0, 0, 0));
    vt.push_back(mk(32'hFFF22183, FMT_I, 3, 4, 0, 2, 0,
                    64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 0, 0, 0));
    vt.push_back(mk(32'h00023183, FMT_I, 3, 4, 0, 3, 0,
                    64'd0, 1, 1, 0, 1, 0));
    vt.push_back(mk(32'hC0002573, FMT_SYS, 0, 0, 0, 2, 0,
                    64'hC00, 0, 0, 0, 0, 0));
    vt.push_back(mk(32'h0FF0000F, FMT_I, 0, 0, 0, 0, 0,
                    64'hFF, 0, 0, 0, 0, 0));
    vt.push_back(mk(32'h40315093, FMT_I, 1, 2, 0, 5, 7'h20,
                    64'h403, 1, 1, 0, 0, 0));
    vt.push_back(mk(32'h40209033, FMT_R, 0, 1, 2, 1, 7'h20,
                    64'd0, 1, 1, 1, 1, 1));
    vt.push_back(mk(32'h000090E7, FMT_I, 1, 1, 0, 1, 0,
                    64'd0, 1, 1, 0, 1, 1));
    vt.push_back(mk(32'h00000001, FMT_NONE, 0, 0, 0, 0, 0,
                    64'd0, 0, 0, 0, 1, 1));
    vt.push_back(mk(32'h0020B423, FMT_S, 0, 1, 2, 3, 0,
                    64'd8, 0, 1, 1, 1, 0));
    vt.push_back(mk(32'h00002063, FMT_B, 0, 0, 0, 2, 0,
                    64'd0, 0, 1, 1, 1, 1));

    #2;
    do_reset();

    send(0);
    chk("t1_valid", {out_valid_a, out_valid_b}, 2'b11);
    chk("t1_cnt_dec", {cd_a, cd_b}, {4'd1, 4'd1});
    chk("t1_cnt_ill", {ci_a, ci_b}, 0);
    drain();

    for (int i = 1; i < 17; i++) send(i);
    drain();
    chk("str_cnt_dec", {cd_a, cd_b}, {4'd15, 4'd15});
    chk("str_cnt_ill", {ci_a, ci_b}, {4'd8, 4'd5});

    out_ready = 1'b0;
    send(0);
    in_valid = 1'b1;
    in_instr = vt[1].instr;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready", {in_ready_a, in_ready_b}, 0);
      chk("bp_valid", {out_valid_a, out_valid_b}, 2'b11);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      send(i);
      chk("bp_nobubble", last_wait, 0);
      chk("bp_stream", {out_valid_a, out_valid_b}, 2'b11);
    end
    drain();

    send(0);
    send(1);
    chk("mid_valid", {out_valid_a, out_valid_b}, 2'b11);
    do_reset();

    out_ready = 1'b0;
    send(4);
    flush = 1'b1;
    in_valid = 1'b1;
    in_instr = vt[5].instr;
    out_ready = 1'b1;
    @(negedge clk);
    chk("fl_in_ready", {in_ready_a, in_ready_b}, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", {out_valid_a, out_valid_b}, 0);
    chk("fl_cnt_dec", {cd_a, cd_b}, {4'd1, 4'd1});
    chk("fl_cnt_ill", {ci_a, ci_b}, 0);
    drain();

    do_reset();
    for (int i = 0; i < 14; i++) send(i);
    chk("sat_dec14", {cd_a, cd_b}, {4'd14, 4'd14});
    chk("sat_ill14", {ci_a, ci_b}, {4'd5, 4'd3});
    for (int i = 14; i < 17; i++) send(i);
    chk("sat_dec15", {cd_a, cd_b}, {4'd15, 4'd15});
    chk("sat_ill17", {ci_a, ci_b}, {4'd8, 4'd5});
    drain();
    chk("sat_hold", {cd_a, cd_b}, {4'd15, 4'd15});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
